// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W      = 12;
    localparam int unsigned APB_DATA_W      = 32;
    localparam int unsigned APB_TIMEOUT_CYC = 255;

    // APB requester phases; 2-bit encoding shared by future APB blocks.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_cmd_master.sv
// APB3 requester: one register access per command, SETUP/ACCESS sequencing,
// PREADY wait states, response returned on a valid/ready channel.
// Optional feature macro: APB_TIMEOUT_EN (abandons an ACCESS after TIMEOUT_CYC cycles).
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic              cmd_write_i,
    // response channel
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    // APB requester side
    output logic [ADDR_W-1:0] PADDR_o,
    output logic [DATA_W-1:0] PWDATA_o,
    output logic              PWRITE_o,
    output logic              PSEL_o,
    output logic              PENABLE_o,
    input  logic [DATA_W-1:0] PRDATA_i,
    input  logic              PREADY_i,
    input  logic              PSLVERR_i,
    // status
    output logic              busy_o
);

    apb_state_e          r_state;
    apb_state_e          w_next_state;

    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_cmd_accept;
    logic                w_access_done;
    logic                w_timeout;

    logic                w_psel;
    logic                w_penable;
    logic                w_rsp_valid;
    logic                w_cmd_ready;
    logic                w_busy;

    assign w_cmd_accept  = cmd_valid_i && (r_state == ST_IDLE);
    assign w_access_done = (r_state == ST_ACCESS) && PREADY_i;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // PREADY-low cycle counter for the current ACCESS phase; cleared in SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !PREADY_i && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && !PREADY_i &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the timeout the ACCESS phase waits on PREADY forever.
    assign w_timeout = 1'b0 & (TIMEOUT_CYC == 32'd0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (cmd_valid_i)                w_next_state = ST_SETUP;
            ST_SETUP:                                  w_next_state = ST_ACCESS;
            ST_ACCESS: if (PREADY_i || w_timeout)      w_next_state = ST_RESP;
            ST_RESP:   if (rsp_ready_i)                w_next_state = ST_IDLE;
            default:                                   w_next_state = ST_IDLE;
        endcase
    end

    // Control outputs decoded purely from the state register.
    always_comb begin
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_rsp_valid = 1'b0;
        w_cmd_ready = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            ST_SETUP: begin
                w_psel = 1'b1;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // Command latch; address/data/direction hold their value until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_cmd_accept) begin
            r_paddr  <= cmd_addr_i;
            r_pwdata <= cmd_wdata_i;
            r_pwrite <= cmd_write_i;
        end
    end

    // Response capture: sampled only on the completing ACCESS cycle or on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access_done) begin
            r_err   <= PSLVERR_i;
            r_rdata <= (r_pwrite || PSLVERR_i) ? '0 : PRDATA_i;
        end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
        end
    end

    assign PADDR_o     = r_paddr;
    assign PWDATA_o    = r_pwdata;
    assign PWRITE_o    = r_pwrite;
    assign PSEL_o      = w_psel;
    assign PENABLE_o   = w_penable;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign cmd_ready_o = w_cmd_ready;
    assign busy_o      = w_busy;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed cases plus randomized
// transactions compared against a transaction-level expectation model.
module tb_apb_cmd_master;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int          TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          cmd_write_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] PADDR_o;
    logic [DW-1:0] PWDATA_o;
    logic          PWRITE_o;
    logic          PSEL_o;
    logic          PENABLE_o;
    logic [DW-1:0] PRDATA_i;
    logic          PREADY_i;
    logic          PSLVERR_i;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_write_i (cmd_write_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .PADDR_o     (PADDR_o),
        .PWDATA_o    (PWDATA_o),
        .PWRITE_o    (PWRITE_o),
        .PSEL_o      (PSEL_o),
        .PENABLE_o   (PENABLE_o),
        .PRDATA_i    (PRDATA_i),
        .PREADY_i    (PREADY_i),
        .PSLVERR_i   (PSLVERR_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with a scripted slave: wt PREADY-low cycles, then a
    // ready cycle carrying serr/prd, then the response held for 'hold' cycles.
    task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic wr, input int wt, input logic serr,
                          input logic [DW-1:0] prd, input int hold);
        int            k;
        bit            timed_out;
        int            exp_acc;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;

        timed_out = TO_EN && (wt >= TO);
        exp_acc   = timed_out ? TO : wt + 1;
        exp_err   = timed_out ? 1'b1 : serr;
        exp_rdata = (wr || exp_err) ? '0 : prd;

        chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_write_i = wr;
        step();
        // Scramble the command bus to prove the request was latched.
        cmd_valid_i = 1'b0;
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = $urandom;
        cmd_write_i = 1'($urandom);

        chk("setup_psel",    64'(PSEL_o),      64'd1);
        chk("setup_penable", 64'(PENABLE_o),   64'd0);
        chk("setup_paddr",   64'(PADDR_o),     64'(addr));
        chk("setup_pwdata",  64'(PWDATA_o),    64'(wdata));
        chk("setup_pwrite",  64'(PWRITE_o),    64'(wr));
        chk("setup_cmd_rdy", 64'(cmd_ready_o), 64'd0);
        chk("setup_busy",    64'(busy_o),      64'd1);
        PREADY_i  = 1'b0;
        PRDATA_i  = $urandom;
        PSLVERR_i = 1'($urandom);
        step();

        chk("access_penable", 64'(PENABLE_o), 64'd1);
        chk("access_psel",    64'(PSEL_o),    64'd1);
        k = 0;
        while (PENABLE_o === 1'b1 && k < 1000) begin
            if (PADDR_o !== addr || PWRITE_o !== wr || PWDATA_o !== wdata)
                chk("access_bus_stable", {PWRITE_o, 20'd0, PADDR_o, PWDATA_o},
                    {wr, 20'd0, addr, wdata});
            PREADY_i  = (k == wt);
            PRDATA_i  = (k == wt) ? prd : DW'($urandom);
            PSLVERR_i = (k == wt) ? serr : 1'($urandom);
            step();
            k++;
        end
        PREADY_i  = 1'b0;
        PRDATA_i  = $urandom;
        PSLVERR_i = 1'($urandom);

        chk("access_cycles", 64'(k),           64'(exp_acc));
        chk("rsp_valid",     64'(rsp_valid_o), 64'd1);
        chk("rsp_psel",      64'(PSEL_o),      64'd0);
        chk("rsp_penable",   64'(PENABLE_o),   64'd0);
        chk("rsp_err",       64'(rsp_err_o),   64'(exp_err));
        chk("rsp_rdata",     64'(rsp_rdata_o), 64'(exp_rdata));

        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid",     64'(rsp_valid_o), 64'd1);
            chk("hold_rdata",     64'(rsp_rdata_o), 64'(exp_rdata));
            chk("hold_err",       64'(rsp_err_o),   64'(exp_err));
            chk("hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
        end

        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("post_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("post_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("post_busy",      64'(busy_o),      64'd0);
        chk("post_paddr",     64'(PADDR_o),     64'(addr));
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_write_i = 1'b0;
        rsp_ready_i = 1'b0;
        PRDATA_i    = '0;
        PREADY_i    = 1'b0;
        PSLVERR_i   = 1'b0;

        repeat (3) step();
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_psel",      64'(PSEL_o),      64'd0);
        chk("rst_penable",   64'(PENABLE_o),   64'd0);
        chk("rst_busy",      64'(busy_o),      64'd0);
        chk("rst_paddr",     64'(PADDR_o),     64'd0);
        chk("rst_pwdata",    64'(PWDATA_o),    64'd0);
        chk("rst_rdata",     64'(rsp_rdata_o), 64'd0);
        chk("rst_err",       64'(rsp_err_o),   64'd0);
        rst_n = 1'b1;
        step();

        // Directed cases.
        do_txn(12'h004, 32'hA5A5_5A5A, 1'b1, 0, 1'b0, 32'hDEAD_BEEF, 0);
        do_txn(12'h010, 32'h0,         1'b0, 3, 1'b0, 32'h1234_5678, 0);
        do_txn(12'h0FC, 32'h0,         1'b0, 0, 1'b1, 32'hCAFE_F00D, 0);
        do_txn(12'h020, 32'h0,         1'b0, 1, 1'b0, 32'h0BAD_CAFE, 5);
        do_txn(12'h024, 32'h1111_2222, 1'b1, 0, 1'b1, 32'h0,         2);
        do_txn(12'h030, 32'h0,         1'b0, 40, 1'b0, 32'h7777_8888, 1);

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            do_txn(AW'($urandom), DW'($urandom), 1'($urandom),
                   int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
                   DW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset pulsed during ACCESS.
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 12'h040;
        cmd_write_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        PREADY_i    = 1'b0;
        step();
        chk("prerst_penable", 64'(PENABLE_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_psel",      64'(PSEL_o),      64'd0);
        chk("midrst_penable",   64'(PENABLE_o),   64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        step();
        rst_n = 1'b1;
        PREADY_i = 1'b1;
        repeat (3) step();
        chk("postrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("postrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("postrst_psel",      64'(PSEL_o),      64'd0);
        PREADY_i = 1'b0;

        // Normal operation resumes after the reset.
        do_txn(12'h044, 32'h0, 1'b0, 2, 1'b0, 32'h5555_AAAA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_cmd_master
